// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC test-pattern and trigger generator.
// Ramp/const/toggle/PRBS15 per channel, plus a periodic trigger.
module adc_pattern_gen #(
  parameter int CHN = 2,
  parameter int DW  = 16,
  parameter int LW  = 16,
  parameter int TW  = 24
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cfg_en_i,
  input  logic [2*CHN-1:0]   cfg_mode_i,
  input  logic [CHN-1:0]     cfg_inv_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic [DW-1:0]      cfg_step_i,
  input  logic [DW-1:0]      cfg_const_i,
  input  logic [TW-1:0]      trg_per_i,
  input  logic [TW-1:0]      trg_len_i,
  output logic [CHN*DW-1:0]  dat_o,
  output logic               dat_vld_o,
  output logic               wrap_o,
  output logic               trg_o,
  output logic [LW-1:0]      idx_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [2*CHN-1:0] mode;
    logic [CHN-1:0]   inv;
    logic [LW-1:0]    len;
    logic [DW-1:0]    step;
    logic [DW-1:0]    cnst;
    logic [TW-1:0]    per;
    logic [TW-1:0]    tlen;
  } cfg_t;

  localparam logic [14:0] SEED = 15'h7FFF;

  state_t      state_q;
  state_t      state_d;
  cfg_t        cfg_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] idx_d;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;
  logic [14:0]   lfsr_q;
  logic [14:0]   lfsr_d;
  logic [TW-1:0] phase_q;
  logic [TW-1:0] phase_d;
  logic          adv;
  logic          idx_wrap;
  logic          ph_wrap;
  logic          trg_d;
  logic [CHN*DW-1:0] dat_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_en_i) state_d = RUN;
      RUN:  if (!cfg_en_i) state_d = IDLE;
    endcase
  end

  // Counters only move while running; any exit restarts them.
  assign adv = (state_q == RUN) && cfg_en_i;

  assign idx_wrap = (cfg_q.len <= LW'(1))
                 || (idx_q == cfg_q.len - LW'(1));
  assign idx_d = idx_wrap ? '0 : idx_q + LW'(1);
  assign acc_d = idx_wrap ? '0 : acc_q + cfg_q.step;
  assign lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};

  assign ph_wrap = (cfg_q.per == '0)
                || (phase_q == cfg_q.per - TW'(1));
  assign phase_d = ph_wrap ? '0 : phase_q + TW'(1);
  assign trg_d = (cfg_q.per != '0) && (phase_q < cfg_q.tlen);

  for (genvar c = 0; c < CHN; c++) begin : g_ch
    logic [DW-1:0] smp;
    always_comb begin
      smp = '0;
      unique case (cfg_q.mode[2*c +: 2])
        2'd0: smp = acc_q;
        2'd1: smp = cfg_q.cnst;
        2'd2: smp = idx_q[0] ? ~cfg_q.cnst : cfg_q.cnst;
        2'd3: smp = DW'(lfsr_q);
      endcase
    end
    assign dat_d[c*DW +: DW] = cfg_q.inv[c] ? ~smp : smp;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_en_i) begin
        cfg_q <= '{mode: cfg_mode_i,
                   inv:  cfg_inv_i,
                   len:  cfg_len_i,
                   step: cfg_step_i,
                   cnst: cfg_const_i,
                   per:  trg_per_i,
                   tlen: trg_len_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q   <= '0;
      acc_q   <= '0;
      lfsr_q  <= SEED;
      phase_q <= '0;
    end else if (adv) begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      lfsr_q  <= lfsr_d;
      phase_q <= phase_d;
    end else begin
      idx_q   <= '0;
      acc_q   <= '0;
      lfsr_q  <= SEED;
      phase_q <= '0;
    end
  end

  // Outputs lag the state by one edge so start and stop are symmetric.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_o     <= '0;
      dat_vld_o <= 1'b0;
      wrap_o    <= 1'b0;
      trg_o     <= 1'b0;
      idx_o     <= '0;
    end else if (state_q == RUN) begin
      dat_o     <= dat_d;
      dat_vld_o <= 1'b1;
      wrap_o    <= (idx_q == '0);
      trg_o     <= trg_d;
      idx_o     <= idx_q;
    end else begin
      dat_o     <= '0;
      dat_vld_o <= 1'b0;
      wrap_o    <= 1'b0;
      trg_o     <= 1'b0;
      idx_o     <= '0;
    end
  end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Directed bench for adc_pattern_gen.
// Each task drives one scenario and checks inline.
module tb_adc_pattern_gen;

  localparam int CHN = 2;
  localparam int DW  = 16;
  localparam int LW  = 16;
  localparam int TW  = 24;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_en;
  logic [2*CHN-1:0]  cfg_mode;
  logic [CHN-1:0]    cfg_inv;
  logic [LW-1:0]     cfg_len;
  logic [DW-1:0]     cfg_step;
  logic [DW-1:0]     cfg_const;
  logic [TW-1:0]     trg_per;
  logic [TW-1:0]     trg_len;
  logic [CHN*DW-1:0] dat;
  logic              dat_vld;
  logic              wrap;
  logic              trg;
  logic [LW-1:0]     idx;
  logic [50:0]       all_o;

  int vectors = 0;
  int miscompares = 0;

  assign all_o = {dat, dat_vld, wrap, trg, idx};

  always #5 clk = ~clk;

  adc_pattern_gen #(
    .CHN(CHN), .DW(DW), .LW(LW), .TW(TW)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .cfg_en_i   (cfg_en),
    .cfg_mode_i (cfg_mode),
    .cfg_inv_i  (cfg_inv),
    .cfg_len_i  (cfg_len),
    .cfg_step_i (cfg_step),
    .cfg_const_i(cfg_const),
    .trg_per_i  (trg_per),
    .trg_len_i  (trg_len),
    .dat_o      (dat),
    .dat_vld_o  (dat_vld),
    .wrap_o     (wrap),
    .trg_o      (trg),
    .idx_o      (idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] mode,
                         input logic [1:0] inv,
                         input logic [15:0] len,
                         input logic [15:0] step,
                         input logic [15:0] cnst,
                         input logic [23:0] per,
                         input logic [23:0] tl);
    cfg_mode  = mode;
    cfg_inv   = inv;
    cfg_len   = len;
    cfg_step  = step;
    cfg_const = cnst;
    trg_per   = per;
    trg_len   = tl;
  endtask

  task automatic start();
    cfg_en = 1'b1;
    tick();
  endtask

  task automatic stop();
    cfg_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want 0", all_o);
    end
    rstn = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h want 0", all_o);
    end
  endtask

  task automatic test_ramp_inv();
    logic [15:0] e0;
    logic [50:0] exp_o;
    int i;
    set_cfg(4'b0000, 2'b10, 16'd30, 16'd4, 16'h0, 24'd0, 24'd0);
    start();
    vectors++;
    if (dat_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_vld_at_n: got %b want 0", dat_vld);
    end
    for (int k = 0; k < 65; k++) begin
      tick();
      i = k % 30;
      e0 = 16'(i * 4);
      exp_o = {~e0, e0, 1'b1, (i == 0), 1'b0, 16'(i)};
      vectors++;
      if (all_o !== exp_o) begin
        miscompares++;
        $display("FAIL ramp k=%0d: got %h want %h", k, all_o, exp_o);
      end
    end
    stop();
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL ramp_stop: got %h want 0", all_o);
    end
  endtask

  task automatic test_const_toggle();
    logic [15:0] tog [5];
    logic [50:0] exp_o;
    int i;
    tog[0] = 16'h1234;
    tog[1] = 16'hEDCB;
    tog[2] = 16'h1234;
    tog[3] = 16'hEDCB;
    tog[4] = 16'h1234;
    set_cfg(4'b1001, 2'b00, 16'd5, 16'd0, 16'h1234, 24'd0, 24'd0);
    start();
    for (int k = 0; k < 15; k++) begin
      tick();
      i = k % 5;
      exp_o = {tog[i], 16'h1234, 1'b1, (i == 0), 1'b0, 16'(i)};
      vectors++;
      if (all_o !== exp_o) begin
        miscompares++;
        $display("FAIL toggle k=%0d: got %h want %h", k, all_o, exp_o);
      end
    end
    stop();
  endtask

  task automatic test_prbs();
    logic [14:0] m;
    logic [15:0] s;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] c1;
    logic [15:0] rep;
    int bad;
    int zero;
    int early;
    m = 15'h7FFF;
    bad = 0;
    zero = 0;
    early = 0;
    s0 = '0; s1 = '0; s2 = '0; c1 = '0; rep = '0;
    set_cfg(4'b1111, 2'b10, 16'd0, 16'd0, 16'h0, 24'd0, 24'd0);
    start();
    for (int k = 0; k < 32768; k++) begin
      tick();
      s = dat[15:0];
      if (k == 0) begin
        s0 = s;
        c1 = dat[31:16];
      end
      if (k == 1) s1 = s;
      if (k == 2) s2 = s;
      if (k < 32767) begin
        if (s !== {1'b0, m}) bad++;
        if (dat[31:16] !== ~s) bad++;
        if (wrap !== 1'b1 || idx !== 16'd0) bad++;
        if (s == 16'd0) zero++;
        if (k > 0 && s == 16'h7FFF) early++;
        m = {m[13:0], m[14] ^ m[13]};
      end else begin
        rep = s;
      end
    end
    stop();
    vectors++;
    if (s0 !== 16'h7FFF) begin
      miscompares++;
      $display("FAIL prbs_first: got %h want 7fff", s0);
    end
    vectors++;
    if (c1 !== 16'h8000) begin
      miscompares++;
      $display("FAIL prbs_inv_first: got %h want 8000", c1);
    end
    vectors++;
    if (s1 !== 16'h7FFE || s2 !== 16'h7FFC) begin
      miscompares++;
      $display("FAIL prbs_next: got %h %h want 7ffe 7ffc", s1, s2);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL prbs_seq: got %0d bad samples want 0", bad);
    end
    vectors++;
    if (zero !== 0) begin
      miscompares++;
      $display("FAIL prbs_zero: got %0d zero samples want 0", zero);
    end
    vectors++;
    if (early !== 0 || rep !== 16'h7FFF) begin
      miscompares++;
      $display("FAIL prbs_period: got early=%0d rep=%h want 0 7fff",
               early, rep);
    end
  endtask

  task automatic run_trg(input string name,
                         input logic [23:0] per,
                         input logic [23:0] tl,
                         input int n,
                         input int exp_hi);
    logic expt;
    int bad;
    int hi;
    bad = 0;
    hi = 0;
    set_cfg(4'b0000, 2'b00, 16'd0, 16'd0, 16'h0, per, tl);
    start();
    for (int k = 0; k < n; k++) begin
      tick();
      if (per == 24'd0) expt = 1'b0;
      else expt = (k % int'(per)) < int'(tl);
      if (trg !== expt) bad++;
      if (trg === 1'b1) hi++;
    end
    stop();
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL trg_%s: got %0d bad cycles want 0", name, bad);
    end
    vectors++;
    if (hi !== exp_hi) begin
      miscompares++;
      $display("FAIL trg_%s_high: got %0d want %0d", name, hi, exp_hi);
    end
  endtask

  task automatic test_trigger();
    run_trg("p1000", 24'd1000, 24'd120, 2100, 340);
    run_trg("p100k", 24'd100000, 24'd1200, 2500, 1200);
    run_trg("per0", 24'd0, 24'd5, 60, 0);
    run_trg("len_eq_per", 24'd10, 24'd10, 60, 60);
    run_trg("len0", 24'd10, 24'd0, 60, 0);
    run_trg("len_gt_per", 24'd7, 24'd20, 60, 60);
    run_trg("per1", 24'd1, 24'd1, 20, 20);
  endtask

  task automatic test_cfg_isolation();
    logic [15:0] e0;
    logic [50:0] exp_o;
    int i;
    set_cfg(4'b0000, 2'b00, 16'd30, 16'd4, 16'h0, 24'd0, 24'd0);
    start();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 10) begin
        cfg_step  = 16'd7;
        cfg_mode  = 4'b0101;
        cfg_const = 16'hABCD;
        cfg_len   = 16'd8;
        cfg_inv   = 2'b11;
        trg_per   = 24'd10;
        trg_len   = 24'd3;
      end
      e0 = 16'(k * 4);
      exp_o = {e0, e0, 1'b1, (k == 0), 1'b0, 16'(k)};
      vectors++;
      if (all_o !== exp_o) begin
        miscompares++;
        $display("FAIL iso_old k=%0d: got %h want %h", k, all_o, exp_o);
      end
    end
    cfg_en = 1'b0;
    tick();
    exp_o = {16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0};
    vectors++;
    if (all_o !== exp_o) begin
      miscompares++;
      $display("FAIL iso_drop_edge: got %h want %h", all_o, exp_o);
    end
    cfg_en = 1'b1;
    tick();
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL iso_idle_gap: got %h want 0", all_o);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      i = k % 8;
      exp_o = {16'h5432, 16'h5432, 1'b1, (i == 0),
               ((k % 10) < 3), 16'(i)};
      vectors++;
      if (all_o !== exp_o) begin
        miscompares++;
        $display("FAIL iso_new k=%0d: got %h want %h", k, all_o, exp_o);
      end
    end
    stop();
  endtask

  task automatic test_async_reset();
    logic [15:0] e0;
    logic [50:0] exp_o;
    int i;
    set_cfg(4'b0101, 2'b00, 16'd4, 16'd0, 16'h1234, 24'd10, 24'd3);
    start();
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (dat !== 32'h12341234 || dat_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: got %h want 12341234 valid", dat);
    end
    #3;
    rstn = 1'b0;
    #1;
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL arst_immediate: got %h want 0", all_o);
    end
    set_cfg(4'b0000, 2'b00, 16'd6, 16'd3, 16'h0, 24'd4, 24'd1);
    #2;
    rstn = 1'b1;
    tick();
    vectors++;
    if (all_o !== 51'd0) begin
      miscompares++;
      $display("FAIL arst_restart_gap: got %h want 0", all_o);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      i = k % 6;
      e0 = 16'(i * 3);
      exp_o = {e0, e0, 1'b1, (i == 0), ((k % 4) == 0), 16'(i)};
      vectors++;
      if (all_o !== exp_o) begin
        miscompares++;
        $display("FAIL arst_restart k=%0d: got %h want %h",
                 k, all_o, exp_o);
      end
    end
    stop();
  endtask

  initial begin
    rstn = 1'b1;
    cfg_en = 1'b0;
    set_cfg(4'b0000, 2'b00, 16'd0, 16'd0, 16'h0, 24'd0, 24'd0);
    #2;
    rstn = 1'b0;
    test_reset();
    test_ramp_inv();
    test_const_toggle();
    test_prbs();
    test_trigger();
    test_cfg_isolation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
